// File: rtl/clock_core_rpt_pkg.sv
// Shared mode encodings, BCD limits and BCD field arithmetic for the clock core.
package clock_core_rpt_pkg;
   typedef enum logic [1:0] {
      MODE_RUN   = 2'b00,
      MODE_SET_H = 2'b01,
      MODE_SET_M = 2'b10,
      MODE_SET_S = 2'b11
   } mode_e;

   localparam logic [7:0] BCD_HMAX  = 8'h23;
   localparam logic [7:0] BCD_MSMAX = 8'h59;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      if (v == max)          return 8'h00;
      if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
      return v + 8'd1;
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
      if (v == 8'h00)        return max;
      if (v[3:0] == 4'd0)    return {v[7:4] - 4'd1, 4'd9};
      return v - 8'd1;
   endfunction

   // One set-mode step of a field; inc has priority, both are pre-qualified by the caller.
   function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] max,
                                           input logic inc, input logic dec);
      if (inc) return bcd_inc(v, max);
      if (dec) return bcd_dec(v, max);
      return v;
   endfunction

   // 24-hour BCD hour -> {pm, 12-hour BCD hour}.
   function automatic logic [8:0] hour12(input logic [7:0] h);
      logic [4:0] b, r;
      logic       pm;
      b  = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
      pm = (b >= 5'd12);
      if (b == 5'd0)       r = 5'd12;
      else if (b > 5'd12)  r = b - 5'd12;
      else                 r = b;
      return (r >= 5'd10) ? {pm, 4'd1, 4'(r - 5'd10)} : {pm, 4'd0, r[3:0]};
   endfunction
endpackage

// File: rtl/clock_core_rpt_if.sv
// Key inputs and display outputs of the clock core, bundled as one port.
interface clock_core_rpt_if;
   import clock_core_rpt_pkg::*;
   logic       mode_btn, inc_btn, dec_btn, fmt12;
   mode_e      mode;
   logic [7:0] hour_bcd, min_bcd, sec_bcd;
   logic       pm, tick;

   modport master (output mode_btn, inc_btn, dec_btn, fmt12,
                   input  mode, hour_bcd, min_bcd, sec_bcd, pm, tick);
   modport slave  (input  mode_btn, inc_btn, dec_btn, fmt12,
                   output mode, hour_bcd, min_bcd, sec_bcd, pm, tick);
endinterface

// File: rtl/btn_repeat.sv
// Active-low key: synchroniser, press-edge detect and optional hold-to-repeat step pulses.
module btn_repeat #(
   parameter bit REPEAT_EN  = 1'b1,
   parameter int REPEAT_DLY = 500_000,
   parameter int REPEAT_PER = 250_000,
   parameter int SYNC_STG   = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   input  logic clr,
   output logic step,
   output logic held
);
   localparam int CW = $clog2(REPEAT_DLY + 1);

   logic [SYNC_STG-1:0] r_sync;
   logic                r_prev, r_arm, r_late;
   logic [CW-1:0]       r_cnt;
   logic                w_lvl, w_edge, w_hit;

   assign w_lvl  = r_sync[SYNC_STG-1];
   assign w_edge = r_prev & ~w_lvl;
   assign w_hit  = r_late ? (r_cnt == CW'(REPEAT_PER)) : (r_cnt == CW'(REPEAT_DLY));
   assign step   = w_edge | (REPEAT_EN & r_arm & w_hit);
   assign held   = ~w_lvl;

   // r_cnt holds cycles since the last step; a cleared key stays disarmed until a new edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync <= '1;
         r_prev <= 1'b1;
         r_arm  <= 1'b0;
         r_late <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STG-2:0], btn_n};
         r_prev <= w_lvl;
         if (clr || w_lvl) begin
            r_arm  <= 1'b0;
            r_late <= 1'b0;
            r_cnt  <= '0;
         end else if (w_edge) begin
            r_arm  <= 1'b1;
            r_late <= 1'b0;
            r_cnt  <= CW'(1);
         end else if (r_arm) begin
            if (w_hit) begin
               r_late <= 1'b1;
               r_cnt  <= CW'(1);
            end else begin
               r_cnt  <= r_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/clock_core_rpt.sv
// Digital clock core: set-mode FSM, 1-s prescaler, BCD hh:mm:ss and 12/24-hour display.
module clock_core_rpt
   import clock_core_rpt_pkg::*;
#(
   parameter int TICK_DIV   = 1_000_000,
   parameter int REPEAT_DLY = 500_000,
   parameter int REPEAT_PER = 250_000,
   parameter int SYNC_STG   = 2
) (
   input  logic              clk,
   input  logic              reset,
   clock_core_rpt_if.slave   bus
);
   localparam int PW = $clog2(TICK_DIV);

   mode_e        r_mode, w_mode_nxt;
   logic [PW-1:0] r_pre;
   logic [7:0]   r_hour, r_min, r_sec;
   logic         r_tick;
   logic         w_mode_step, w_inc_step, w_dec_step, w_inc_held, w_dec_held;
   logic         w_unused_mode_held;
   logic         w_clr, w_inc_act, w_dec_act, w_tick_now;
   logic         w_run, w_set_h, w_set_m, w_set_s;
   logic [8:0]   w_h12;

   btn_repeat #(.REPEAT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER), .SYNC_STG(SYNC_STG))
      u_mode (.clk(clk), .reset(reset), .btn_n(bus.mode_btn), .clr(1'b0),
              .step(w_mode_step), .held(w_unused_mode_held));
   btn_repeat #(.REPEAT_EN(1'b1), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER), .SYNC_STG(SYNC_STG))
      u_inc  (.clk(clk), .reset(reset), .btn_n(bus.inc_btn), .clr(w_clr),
              .step(w_inc_step), .held(w_inc_held));
   btn_repeat #(.REPEAT_EN(1'b1), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER), .SYNC_STG(SYNC_STG))
      u_dec  (.clk(clk), .reset(reset), .btn_n(bus.dec_btn), .clr(w_clr),
              .step(w_dec_step), .held(w_dec_held));

   // Chords and mode changes disarm inc/dec so a held key needs a fresh press.
   assign w_clr      = w_mode_step | (w_inc_held & w_dec_held);
   assign w_inc_act  = w_inc_step & ~w_dec_held & ~w_mode_step;
   assign w_dec_act  = w_dec_step & ~w_inc_held & ~w_mode_step;
   assign w_tick_now = w_run && (r_pre == PW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_mode <= MODE_RUN;
      else        r_mode <= w_mode_nxt;
   end

   always_comb begin
      w_mode_nxt = r_mode;
      if (w_mode_step) begin
         case (r_mode)
            MODE_RUN:   w_mode_nxt = MODE_SET_H;
            MODE_SET_H: w_mode_nxt = MODE_SET_M;
            MODE_SET_M: w_mode_nxt = MODE_SET_S;
            default:    w_mode_nxt = MODE_RUN;
         endcase
      end
   end

   always_comb begin
      w_run   = 1'b0;
      w_set_h = 1'b0;
      w_set_m = 1'b0;
      w_set_s = 1'b0;
      case (r_mode)
         MODE_RUN:   w_run   = 1'b1;
         MODE_SET_H: w_set_h = 1'b1;
         MODE_SET_M: w_set_m = 1'b1;
         default:    w_set_s = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pre  <= '0;
         r_tick <= 1'b0;
         r_hour <= 8'h00;
         r_min  <= 8'h00;
         r_sec  <= 8'h00;
      end else begin
         r_tick <= w_tick_now;
         r_pre  <= (!w_run || w_tick_now) ? '0 : r_pre + 1'b1;
         if (w_tick_now) begin
            r_sec <= bcd_inc(r_sec, BCD_MSMAX);
            if (r_sec == BCD_MSMAX) begin
               r_min <= bcd_inc(r_min, BCD_MSMAX);
               if (r_min == BCD_MSMAX) r_hour <= bcd_inc(r_hour, BCD_HMAX);
            end
         end
         if (w_set_h) r_hour <= bcd_step(r_hour, BCD_HMAX,  w_inc_act, w_dec_act);
         if (w_set_m) r_min  <= bcd_step(r_min,  BCD_MSMAX, w_inc_act, w_dec_act);
         if (w_set_s) r_sec  <= bcd_step(r_sec,  BCD_MSMAX, w_inc_act, w_dec_act);
      end
   end

   assign w_h12        = hour12(r_hour);
   assign bus.mode     = r_mode;
   assign bus.min_bcd  = r_min;
   assign bus.sec_bcd  = r_sec;
   assign bus.tick     = r_tick;
   assign bus.hour_bcd = bus.fmt12 ? w_h12[7:0] : r_hour;
   assign bus.pm       = bus.fmt12 & w_h12[8];
endmodule

// File: tb/tb_clock_core_rpt.sv
// Scoreboard bench for clock_core_rpt with short tick/repeat parameters.
module tb_clock_core_rpt;
   import clock_core_rpt_pkg::*;

   localparam int TD = 10, RD = 8, RP = 4;

   typedef struct {
      string       tag;
      logic [31:0] v;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   exp_t sb_q[$];
   int   n_cmp = 0, n_err = 0, tick_cnt = 0, t0 = 0;

   clock_core_rpt_if bus();

   clock_core_rpt #(.TICK_DIV(TD), .REPEAT_DLY(RD), .REPEAT_PER(RP), .SYNC_STG(2))
      dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.tick === 1'b1) tick_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_v(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      sb_q.push_back(e);
   endtask

   task automatic observe(input logic [31:0] obs);
      exp_t e;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'(sb_q.size()), 32'd1);
         return;
      end
      e = sb_q.pop_front();
      chk(e.tag, obs, e.v);
   endtask

   task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                             input logic [7:0] s);
      expect_v({tag, "_h"}, 32'(h));
      expect_v({tag, "_m"}, 32'(m));
      expect_v({tag, "_s"}, 32'(s));
      observe(32'(bus.hour_bcd));
      observe(32'(bus.min_bcd));
      observe(32'(bus.sec_bcd));
   endtask

   task automatic check_mode(input string tag, input logic [1:0] m);
      expect_v(tag, 32'(m));
      observe(32'(bus.mode));
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_btn(input int which, input logic v);
      case (which)
         0:       bus.mode_btn = v;
         1:       bus.inc_btn  = v;
         default: bus.dec_btn  = v;
      endcase
   endtask

   task automatic press(input int which);
      set_btn(which, 1'b0);
      cyc(4);
      set_btn(which, 1'b1);
      cyc(4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.mode_btn = 1'b1;
      bus.inc_btn  = 1'b1;
      bus.dec_btn  = 1'b1;
      bus.fmt12    = 1'b0;
      cyc(2);
      check_time("rst", 8'h00, 8'h00, 8'h00);
      check_mode("rst_mode", 2'b00);
      expect_v("rst_tick", 0); observe(32'(bus.tick));
      bus.fmt12 = 1'b1; #1;
      expect_v("rst_h12", 32'h12); observe(32'(bus.hour_bcd));
      expect_v("rst_pm", 0);       observe(32'(bus.pm));
      bus.fmt12 = 1'b0;
      cyc(1);
      reset = 1'b1;

      // preset 23:59:58 through set mode
      press(0); check_mode("m_seth", 2'b01);
      press(2); expect_v("pre_h", 32'h23); observe(32'(bus.hour_bcd));
      press(0); check_mode("m_setm", 2'b10);
      press(2); expect_v("pre_m", 32'h59); observe(32'(bus.min_bcd));
      press(0); check_mode("m_sets", 2'b11);
      press(2); press(2);
      press(0); check_mode("m_run", 2'b00);
      check_time("pre", 8'h23, 8'h59, 8'h58);

      // 1: async reset mid-run, then two ticks in 20 cycles
      reset = 1'b0; #1;
      check_time("t1_rst", 8'h00, 8'h00, 8'h00);
      check_mode("t1_mode", 2'b00);
      cyc(2);
      reset = 1'b1;
      t0 = tick_cnt;
      cyc(20);
      expect_v("t1_sec", 32'h02); observe(32'(bus.sec_bcd));
      cyc(1);
      expect_v("t1_ticks", 2); observe(32'(tick_cnt - t0));

      // 2: 23:59:59 rolls to 00:00:00 exactly TD cycles after the mode edge
      press(0); press(2);
      press(0); press(2);
      press(0); press(2); press(2); press(2);
      check_time("t2_pre", 8'h23, 8'h59, 8'h59);
      press(0);
      cyc(4);
      expect_v("t2_notick", 0); observe(32'(bus.tick));
      check_time("t2_n12", 8'h23, 8'h59, 8'h59);
      cyc(1);
      expect_v("t2_tick", 1); observe(32'(bus.tick));
      check_time("t2_wrap", 8'h00, 8'h00, 8'h00);
      bus.fmt12 = 1'b1; #1;
      expect_v("t2_h12", 32'h12); observe(32'(bus.hour_bcd));
      expect_v("t2_pm", 0);       observe(32'(bus.pm));
      bus.fmt12 = 1'b0;

      // 4: hour 00 - 1 wraps to 23, shown as 11 PM
      press(0); check_mode("t4_mode", 2'b01);
      press(2);
      expect_v("t4_h", 32'h23); observe(32'(bus.hour_bcd));
      bus.fmt12 = 1'b1; #1;
      expect_v("t4_h12", 32'h11); observe(32'(bus.hour_bcd));
      expect_v("t4_pm", 1);       observe(32'(bus.pm));
      bus.fmt12 = 1'b0; #1;
      expect_v("t4_pm24", 0);     observe(32'(bus.pm));

      // 3: held inc from 58 steps at 0, RD, RD+RP, RD+2*RP past the press edge
      press(0); check_mode("t3_mode", 2'b10);
      press(2); press(2);
      expect_v("t3_start", 32'h58); observe(32'(bus.min_bcd));
      set_btn(1, 1'b0);
      expect_v("t3_n2",  32'h58);
      expect_v("t3_n3",  32'h59);
      expect_v("t3_n10", 32'h59);
      expect_v("t3_n11", 32'h00);
      expect_v("t3_n15", 32'h01);
      expect_v("t3_n19", 32'h02);
      for (int i = 1; i <= 19; i++) begin
         cyc(1);
         if (i == 18) set_btn(1, 1'b1);
         if (i == 2 || i == 3 || i == 10 || i == 11 || i == 15 || i == 19)
            observe(32'(bus.min_bcd));
      end
      cyc(10);
      check_time("t3_end", 8'h23, 8'h02, 8'h00);

      // 5: inc+dec chord does nothing and leaves inc disarmed
      press(0); check_mode("t5_mode", 2'b11);
      set_btn(1, 1'b0); set_btn(2, 1'b0);
      cyc(30);
      expect_v("t5_both", 32'h00); observe(32'(bus.sec_bcd));
      set_btn(2, 1'b1);
      cyc(20);
      expect_v("t5_inc_held", 32'h00); observe(32'(bus.sec_bcd));
      set_btn(1, 1'b1);
      cyc(4);
      press(1);
      expect_v("t5_repress", 32'h01); observe(32'(bus.sec_bcd));
      press(0); check_mode("t5_run", 2'b00);

      // 6: reset mid-count restarts the prescaler; inc ignored in RUN
      cyc(3);
      reset = 1'b0; #1;
      check_time("t6_rst", 8'h00, 8'h00, 8'h00);
      cyc(1);
      reset = 1'b1;
      set_btn(1, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         cyc(1);
         if (i == 4) set_btn(1, 1'b1);
         if (i == 9) begin
            expect_v("t6_n9_tick", 0); observe(32'(bus.tick));
            check_time("t6_n9", 8'h00, 8'h00, 8'h00);
         end
         if (i == 10) begin
            expect_v("t6_n10_tick", 1); observe(32'(bus.tick));
            check_time("t6_n10", 8'h00, 8'h00, 8'h01);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
